// File: rtl/aclk_multi_alarm_display.sv
// Alarm-clock display stage with a table of programmable alarms.
// Drives registered ASCII LCD digits and a ring/snooze/auto-off sequencer paced by the minute strobe.
module aclk_multi_alarm_display #(
    parameter int NUM_ALARMS     = 4,
    parameter int SNOOZE_MINUTES = 5,
    parameter int RING_MINUTES   = 2,
    localparam int SW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          one_minute,
    input  logic [15:0]   current_time,
    input  logic [15:0]   key_time,
    input  logic          alarm_wr,
    input  logic          alarm_en_in,
    input  logic [SW-1:0] alarm_sel,
    input  logic          show_alarm,
    input  logic          show_key,
    input  logic          snooze,
    input  logic          stop,
    output logic [7:0]    display_ms_hr,
    output logic [7:0]    display_ls_hr,
    output logic [7:0]    display_ms_min,
    output logic [7:0]    display_ls_min,
    output logic          sound_alarm,
    output logic [SW-1:0] active_slot
);

    localparam int MAXM = (RING_MINUTES > SNOOZE_MINUTES) ? RING_MINUTES : SNOOZE_MINUTES;
    localparam int CW   = $clog2(MAXM + 1);
    localparam logic [CW-1:0] RING_LIM   = CW'(RING_MINUTES);
    localparam logic [CW-1:0] SNOOZE_LIM = CW'(SNOOZE_MINUTES);

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;

    function automatic logic [7:0] to_ascii(input logic [3:0] nib);
        return (nib <= 4'd9) ? (8'h30 + {4'h0, nib}) : 8'h2D;
    endfunction

    logic [NUM_ALARMS-1:0][15:0] slot_time;
    logic [NUM_ALARMS-1:0]       slot_en;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ALARMS; gi++) begin : g_slot
            logic [15:0] time_q;
            logic        en_q;
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    time_q <= 16'h0000;
                    en_q   <= 1'b0;
                end else if (alarm_wr && (alarm_sel == SW'(gi))) begin
                    time_q <= key_time;
                    en_q   <= alarm_en_in;
                end
            end
            assign slot_time[gi] = time_q;
            assign slot_en[gi]   = en_q;
        end
    endgenerate

    // Out-of-range selects fall back to the current time for display.
    logic [15:0]   sel_time;
    logic [15:0]   src_time;
    logic          hit;
    logic [SW-1:0] hit_idx;

    always_comb begin
        sel_time = current_time;
        hit      = 1'b0;
        hit_idx  = '0;
        // Descending scan so the lowest matching slot is the one left standing.
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (alarm_sel == SW'(i)) begin
                sel_time = slot_time[i];
            end
            if (slot_en[i] && (slot_time[i] == current_time)) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
            end
        end
        if (show_key) begin
            src_time = key_time;
        end else if (show_alarm) begin
            src_time = sel_time;
        end else begin
            src_time = current_time;
        end
    end

    logic [3:0][7:0] disp_q, disp_d;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign disp_d[gi] = to_ascii(src_time[gi*4 +: 4]);
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            disp_q <= {4{8'h30}};
        end else begin
            disp_q <= disp_d;
        end
    end

    assign display_ms_hr  = disp_q[3];
    assign display_ls_hr  = disp_q[2];
    assign display_ms_min = disp_q[1];
    assign display_ls_min = disp_q[0];

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] slot_q, slot_d;
    logic          sound_q, sound_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            slot_q  <= '0;
            sound_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            sound_q <= sound_d;
        end
    end

    // One counter serves both ringing and snoozing; it is cleared on every entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        case (state_q)
            IDLE: begin
                if (one_minute && hit) begin
                    state_d = RINGING;
                    slot_d  = hit_idx;
                    cnt_d   = '0;
                end
            end
            RINGING: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (snooze) begin
                    state_d = SNOOZED;
                    cnt_d   = '0;
                end else if (one_minute) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == RING_LIM) begin
                        state_d = IDLE;
                    end
                end
            end
            SNOOZED: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (one_minute) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == SNOOZE_LIM) begin
                        state_d = RINGING;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        sound_d = (state_d == RINGING);
    end

    assign sound_alarm = sound_q;
    assign active_slot = slot_q;

endmodule

// File: tb/tb_aclk_multi_alarm_display.sv
// Bench for aclk_multi_alarm_display: display vector table, hand-written alarm sequences,
// then randomized traffic checked against a behavioural model of the alarm rules.
module tb_aclk_multi_alarm_display;

    localparam int NA  = 4;
    localparam int SNZ = 5;
    localparam int RNG = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        one_minute;
    logic [15:0] current_time;
    logic [15:0] key_time;
    logic        alarm_wr;
    logic        alarm_en_in;
    logic [1:0]  alarm_sel;
    logic        show_alarm;
    logic        show_key;
    logic        snooze;
    logic        stop;
    logic [7:0]  display_ms_hr, display_ls_hr, display_ms_min, display_ls_min;
    logic        sound_alarm;
    logic [1:0]  active_slot;

    aclk_multi_alarm_display #(
        .NUM_ALARMS(NA), .SNOOZE_MINUTES(SNZ), .RING_MINUTES(RNG)
    ) dut (
        .clock(clock), .reset(reset), .one_minute(one_minute),
        .current_time(current_time), .key_time(key_time),
        .alarm_wr(alarm_wr), .alarm_en_in(alarm_en_in), .alarm_sel(alarm_sel),
        .show_alarm(show_alarm), .show_key(show_key), .snooze(snooze), .stop(stop),
        .display_ms_hr(display_ms_hr), .display_ls_hr(display_ls_hr),
        .display_ms_min(display_ms_min), .display_ls_min(display_ls_min),
        .sound_alarm(sound_alarm), .active_slot(active_slot)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: alarm table plus a mode (0 quiet, 1 ringing, 2 snoozing)
    // and the number of minutes spent in the current ringing/snoozing period.
    logic [15:0] m_time [NA];
    bit          m_en   [NA];
    int          m_mode;
    int          m_slot;
    int          m_minutes;
    logic [31:0] exp_disp;

    typedef struct {
        bit          sk;
        bit          sa;
        logic [1:0]  sel;
        logic [15:0] cur;
        logic [15:0] key;
        logic [31:0] disp;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [31:0] ascii_of(input logic [15:0] t);
        logic [31:0] r = 0;
        for (int k = 0; k < 4; k++) begin
            int nib = (t >> (4 * k)) & 15;
            int ch  = (nib < 10) ? (48 + nib) : 45;
            r = r | (32'(ch) << (8 * k));
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    function automatic logic [31:0] disp_now();
        return {display_ms_hr, display_ls_hr, display_ms_min, display_ls_min};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NA; i++) begin
            m_time[i] = 16'h0000;
            m_en[i]   = 0;
        end
        m_mode = 0;
        m_slot = 0;
        m_minutes = 0;
    endtask

    // Apply the current inputs over one rising edge, advance the model, compare all outputs.
    task automatic step();
        logic [15:0] shown;
        shown = current_time;
        if (show_key) shown = key_time;
        else if (show_alarm) shown = m_time[alarm_sel];
        exp_disp = ascii_of(shown);

        if (m_mode == 0) begin
            if (one_minute) begin
                for (int i = 0; i < NA; i++) begin
                    if (m_mode == 0 && m_en[i] && m_time[i] == current_time) begin
                        m_mode = 1;
                        m_slot = i;
                        m_minutes = 0;
                    end
                end
            end
        end else if (stop) begin
            m_mode = 0;
        end else if (m_mode == 1 && snooze) begin
            m_mode = 2;
            m_minutes = 0;
        end else if (one_minute) begin
            m_minutes++;
            if (m_mode == 1 && m_minutes == RNG) m_mode = 0;
            else if (m_mode == 2 && m_minutes == SNZ) begin
                m_mode = 1;
                m_minutes = 0;
            end
        end

        if (alarm_wr) begin
            m_time[alarm_sel] = key_time;
            m_en[alarm_sel]   = alarm_en_in;
        end

        @(posedge clock);
        #1;
        check("display", disp_now(), exp_disp);
        check("sound_alarm", 32'(sound_alarm), 32'(m_mode == 1));
        check("active_slot", 32'(active_slot), 32'(m_slot));
        one_minute = 0;
        alarm_wr   = 0;
        snooze     = 0;
        stop       = 0;
    endtask

    task automatic write_slot(input int s, input logic [15:0] t, input bit en);
        alarm_sel   = 2'(s);
        key_time    = t;
        alarm_en_in = en;
        alarm_wr    = 1;
        step();
    endtask

    task automatic strobe(input logic [15:0] t);
        current_time = t;
        one_minute   = 1;
        step();
    endtask

    task automatic do_reset();
        reset = 1;
        #2;
        check("reset_sound", 32'(sound_alarm), 32'h0);
        check("reset_display", disp_now(), 32'h30303030);
        check("reset_active", 32'(active_slot), 32'h0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 0;
        model_reset();
    endtask

    function automatic logic [15:0] pick_time();
        case ($urandom_range(0, 3))
            0: return 16'h0700;
            1: return 16'h0701;
            2: return 16'h0815;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        vecs[0] = '{1, 0, 2'd0, 16'h0945, 16'h1030, 32'h31303330};
        vecs[1] = '{0, 1, 2'd2, 16'h0945, 16'h1030, 32'h31353030};
        vecs[2] = '{0, 0, 2'd2, 16'h0945, 16'h1030, 32'h30393435};
        vecs[3] = '{1, 0, 2'd0, 16'h0945, 16'hA9F0, 32'h2D392D30};
        vecs[4] = '{0, 1, 2'd0, 16'h1234, 16'h1030, 32'h30303030};
        vecs[5] = '{1, 1, 2'd2, 16'h0945, 16'h2359, 32'h32333539};

        one_minute   = 1'($urandom);
        current_time = 16'($urandom);
        key_time     = 16'($urandom);
        alarm_wr     = 1'($urandom);
        alarm_en_in  = 1'($urandom);
        alarm_sel    = 2'($urandom);
        show_alarm   = 1'($urandom);
        show_key     = 1'($urandom);
        snooze       = 1'($urandom);
        stop         = 1'($urandom);
        do_reset();
        {one_minute, alarm_wr, snooze, stop, show_alarm, show_key} = '0;
        current_time = 16'h0945;

        write_slot(2, 16'h1500, 1);
        foreach (vecs[v]) begin
            show_key     = vecs[v].sk;
            show_alarm   = vecs[v].sa;
            alarm_sel    = vecs[v].sel;
            current_time = vecs[v].cur;
            key_time     = vecs[v].key;
            step();
            check($sformatf("vec%0d", v), disp_now(), vecs[v].disp);
        end
        {show_key, show_alarm} = '0;
        current_time = 16'h0945;

        write_slot(1, 16'h0700, 1);
        write_slot(3, 16'h0700, 1);
        write_slot(0, 16'h0700, 0);
        strobe(16'h0700);
        check("trigger_sound", 32'(sound_alarm), 32'h1);
        check("trigger_slot", 32'(active_slot), 32'h1);
        strobe(16'h0701);
        check("autooff_first", 32'(sound_alarm), 32'h1);
        strobe(16'h0702);
        check("autooff_second", 32'(sound_alarm), 32'h0);

        strobe(16'h0700);
        check("retrigger", 32'(sound_alarm), 32'h1);
        snooze = 1;
        step();
        check("snooze_quiet", 32'(sound_alarm), 32'h0);
        for (int m = 1; m < SNZ; m++) begin
            strobe(16'h0800);
            check($sformatf("snoozing_%0d", m), 32'(sound_alarm), 32'h0);
        end
        strobe(16'h0800);
        check("rering", 32'(sound_alarm), 32'h1);
        stop = 1;
        snooze = 1;
        step();
        check("stop_over_snooze", 32'(sound_alarm), 32'h0);
        for (int m = 0; m < SNZ + 1; m++) strobe(16'h0800);
        check("no_rering", 32'(sound_alarm), 32'h0);

        strobe(16'h0700);
        write_slot(1, 16'h0700, 0);
        write_slot(0, 16'h0800, 1);
        strobe(16'h0800);
        check("ignored_match_slot", 32'(active_slot), 32'h1);
        check("ignored_match_sound", 32'(sound_alarm), 32'h1);
        do_reset();
        show_alarm = 1;
        alarm_sel  = 2'd2;
        strobe(16'h1500);
        check("cleared_slot_display", disp_now(), 32'h30303030);
        check("cleared_slot_silent", 32'(sound_alarm), 32'h0);
        show_alarm = 0;

        for (int c = 0; c < 400; c++) begin
            current_time = pick_time();
            key_time     = pick_time();
            one_minute   = ($urandom_range(0, 2) == 0);
            alarm_wr     = ($urandom_range(0, 5) == 0);
            alarm_en_in  = ($urandom_range(0, 3) != 0);
            alarm_sel    = 2'($urandom);
            show_key     = ($urandom_range(0, 3) == 0);
            show_alarm   = ($urandom_range(0, 2) == 0);
            snooze       = ($urandom_range(0, 7) == 0);
            stop         = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
